// File: rtl/fpu_move_unit.sv
// Floating-point move/negate/absolute unit with a small in-order result queue.
// Sign-only operations; exponent and mantissa (including NaN payloads) pass through untouched.
module fpu_move_unit #(
    parameter int unsigned EXP_W  = 8,
    parameter int unsigned MAN_W  = 23,
    parameter int unsigned DEPTH  = 2,
    parameter logic [3:0]  OP_MOV = 4'd9,
    parameter logic [3:0]  OP_NEG = 4'd10,
    parameter logic [3:0]  OP_ABS = 4'd11
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [EXP_W+MAN_W:0]       a,
    input  logic [3:0]                 operation,
    input  logic                       in_valid,
    output logic                       in_ready,
    output logic [EXP_W+MAN_W:0]       a_out,
    output logic                       nan_out,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [$clog2(DEPTH):0]     count
);

    localparam int unsigned WIDTH = 1 + EXP_W + MAN_W;
    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wptr;
    logic [PTR_W-1:0] rptr;
    logic [CNT_W-1:0] cnt;

    logic             op_ok_c;
    logic             push_c;
    logic             pop_c;
    logic [WIDTH-1:0] result_c;
    logic [WIDTH-1:0] head_c;

    // Opcode decode and sign manipulation; unrecognised opcodes are consumed without a push.
    always_comb begin
        result_c = a;
        op_ok_c  = 1'b0;
        if (operation == OP_MOV) begin
            op_ok_c = 1'b1;
        end else if (operation == OP_NEG) begin
            op_ok_c            = 1'b1;
            result_c[WIDTH-1]  = ~a[WIDTH-1];
        end else if (operation == OP_ABS) begin
            op_ok_c            = 1'b1;
            result_c[WIDTH-1]  = 1'b0;
        end
    end

    assign out_valid = (cnt != '0);
    assign in_ready  = (cnt < CNT_W'(DEPTH)) || out_ready;
    assign push_c    = in_valid && in_ready && op_ok_c;
    assign pop_c     = out_valid && out_ready;

    // Pointers and occupancy; a full queue with a concurrent pop accepts and retires on one edge.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wptr <= '0;
            rptr <= '0;
            cnt  <= '0;
        end else begin
            if (push_c) begin
                wptr <= wptr + PTR_W'(1);
            end
            if (pop_c) begin
                rptr <= rptr + PTR_W'(1);
            end
            case ({push_c, pop_c})
                2'b10:   cnt <= cnt + CNT_W'(1);
                2'b01:   cnt <= cnt - CNT_W'(1);
                default: cnt <= cnt;
            endcase
        end
    end

    // Storage is not reset; it is only observable through the head while the queue is non-empty.
    always_ff @(posedge clk) begin
        if (push_c && !rst) begin
            mem[wptr] <= result_c;
        end
    end

    assign head_c  = mem[rptr];
    assign a_out   = out_valid ? head_c : '0;
    assign nan_out = out_valid && (&head_c[WIDTH-2 -: EXP_W]) && (|head_c[MAN_W-1:0]);
    assign count   = cnt;

endmodule

// File: tb/tb_fpu_move_unit.sv
// Scoreboard bench for fpu_move_unit: stimulus queues hand-computed results,
// an independent monitor retires them as the DUT pops its head.
module tb_fpu_move_unit;

    typedef struct packed {
        logic [31:0] val;
        logic        nan;
    } exp_t;

    logic        clk;
    logic        rst;
    logic [31:0] a;
    logic [3:0]  operation;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] a_out;
    logic        nan_out;
    logic        out_valid;
    logic        out_ready;
    logic [1:0]  count;

    exp_t sb[$];
    int   n_cmp;
    int   n_err;

    fpu_move_unit dut (
        .clk       (clk),
        .rst       (rst),
        .a         (a),
        .operation (operation),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a_out     (a_out),
        .nan_out   (nan_out),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .count     (count)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Offer one operand; queue the expected result if it is a recognised opcode.
    task automatic send(input logic [31:0] v, input logic [3:0] op,
                        input logic [31:0] e, input logic en, input logic push);
        int w;
        w         = 0;
        a         = v;
        operation = op;
        in_valid  = 1'b1;
        @(negedge clk);
        while (!in_ready && w < 20) begin
            @(negedge clk);
            w++;
        end
        if (!in_ready) begin
            n_cmp++;
            n_err++;
            $display("FAIL send_timeout: in_ready got 0 expected 1 for op %0d", op);
        end else if (push) begin
            sb.push_back('{val: e, nan: en});
        end
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        in_valid = 1'b0;
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Monitor: retire the scoreboard head whenever the DUT pops, and check idle outputs are zero.
    initial begin
        forever begin
            exp_t e;
            @(negedge clk);
            if (!rst) begin
                if (out_valid) begin
                    if (out_ready) begin
                        if (sb.size() == 0) begin
                            n_cmp++;
                            n_err++;
                            $display("FAIL pop_unexpected: got %h expected no result", a_out);
                        end else begin
                            e = sb.pop_front();
                            chk("pop_data", a_out, e.val);
                            chk("pop_nan", 32'(nan_out), 32'(e.nan));
                        end
                    end
                end else begin
                    chk("idle_a_out", a_out, 32'h0);
                    chk("idle_nan", 32'(nan_out), 32'h0);
                end
            end
        end
    end

    initial begin
        clk       = 1'b0;
        rst       = 1'b1;
        a         = '0;
        operation = '0;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        n_cmp     = 0;
        n_err     = 0;

        #1;
        chk("rst_out_valid", 32'(out_valid), 32'h0);
        chk("rst_count", 32'(count), 32'h0);
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        @(posedge clk);
        #1;
        chk("post_rst_in_ready", 32'(in_ready), 32'h1);
        chk("post_rst_a_out", a_out, 32'h0);
        chk("post_rst_count", 32'(count), 32'h0);

        // Basic operations with one-cycle latency
        out_ready = 1'b1;
        send(32'h3F800000, 4'd9, 32'h3F800000, 1'b0, 1'b1);
        chk("mov_latency_valid", 32'(out_valid), 32'h1);
        chk("mov_latency_data", a_out, 32'h3F800000);
        chk("mov_nan", 32'(nan_out), 32'h0);
        idle(2);
        send(32'h3F800000, 4'd10, 32'hBF800000, 1'b0, 1'b1);
        chk("neg_data", a_out, 32'hBF800000);
        idle(1);
        send(32'hC0400000, 4'd11, 32'h40400000, 1'b0, 1'b1);
        chk("abs_data", a_out, 32'h40400000);
        idle(1);
        send(32'h7FC00001, 4'd10, 32'hFFC00001, 1'b1, 1'b1);
        chk("neg_nan_data", a_out, 32'hFFC00001);
        chk("neg_nan_flag", 32'(nan_out), 32'h1);
        idle(1);

        // Back-to-back traffic: push and pop together at occupancy 1
        send(32'h7F800000, 4'd9, 32'h7F800000, 1'b0, 1'b1);
        send(32'hFF800001, 4'd11, 32'h7F800001, 1'b1, 1'b1);
        chk("stream_count_a", 32'(count), 32'h1);
        send(32'h00000000, 4'd10, 32'h80000000, 1'b0, 1'b1);
        chk("stream_count_b", 32'(count), 32'h1);
        idle(3);
        chk("stream_drained", 32'(count), 32'h0);

        // Unrecognised opcode is consumed and dropped
        a         = 32'h3F800000;
        operation = 4'd3;
        in_valid  = 1'b1;
        @(negedge clk);
        chk("discard_in_ready", 32'(in_ready), 32'h1);
        @(posedge clk);
        #1;
        chk("discard_count", 32'(count), 32'h0);
        chk("discard_out_valid", 32'(out_valid), 32'h0);
        idle(1);

        // Fill, stall, then push and pop on the same edge across the pointer wrap
        out_ready = 1'b0;
        send(32'h40000000, 4'd9, 32'h40000000, 1'b0, 1'b1);
        send(32'h40400000, 4'd10, 32'hC0400000, 1'b0, 1'b1);
        chk("full_count", 32'(count), 32'h2);
        a         = 32'h80000005;
        operation = 4'd11;
        @(negedge clk);
        chk("full_in_ready", 32'(in_ready), 32'h0);
        @(posedge clk);
        #1;
        chk("full_hold_count", 32'(count), 32'h2);
        chk("full_hold_head", a_out, 32'h40000000);
        out_ready = 1'b1;
        @(negedge clk);
        chk("full_pop_in_ready", 32'(in_ready), 32'h1);
        sb.push_back('{val: 32'h00000005, nan: 1'b0});
        @(posedge clk);
        #1;
        chk("full_pushpop_count", 32'(count), 32'h2);
        idle(4);
        chk("full_drained", 32'(count), 32'h0);

        // Asynchronous reset mid-operation discards queued results
        out_ready = 1'b0;
        send(32'h11111111, 4'd9, 32'h11111111, 1'b0, 1'b1);
        send(32'h22222222, 4'd9, 32'h22222222, 1'b0, 1'b1);
        in_valid = 1'b0;
        chk("pre_rst_count", 32'(count), 32'h2);
        #2 rst = 1'b1;
        sb.delete();
        #1;
        chk("async_rst_valid", 32'(out_valid), 32'h0);
        chk("async_rst_count", 32'(count), 32'h0);
        chk("async_rst_a_out", a_out, 32'h0);
        chk("async_rst_nan", 32'(nan_out), 32'h0);
        @(posedge clk);
        #1 rst = 1'b0;
        @(posedge clk);
        #1;
        chk("rst_release_in_ready", 32'(in_ready), 32'h1);
        chk("rst_release_count", 32'(count), 32'h0);
        out_ready = 1'b1;
        send(32'h12345678, 4'd9, 32'h12345678, 1'b0, 1'b1);
        idle(3);
        chk("final_count", 32'(count), 32'h0);
        chk("scoreboard_empty", 32'(sb.size()), 32'h0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
